count_dir_decoder: RTL and testbench

COUNT_DIR_DECODER -- requirements
Module: count_dir_decoder

---
 rtl/count_dir_pkg.sv | 17 +
 rtl/count_dir_decoder_if.sv | 10 +
 rtl/count_step_classify.sv | 30 +++
 rtl/count_dir_decoder.sv | 101 ++++++++++
 tb/tb_count_dir_decoder.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/count_dir_pkg.sv
// Shared types for the up/down count direction decoder.
package count_dir_pkg;

    typedef enum logic [1:0] {
        NO_REF,
        ARMED,
        UP,
        DOWN
    } state_t;

    typedef enum logic [1:0] {
        STEP_UP,
        STEP_DOWN,
        STEP_BAD
    } step_t;

endpackage

// File: rtl/count_dir_decoder_if.sv
// Sample stream carrying observed counter values into the decoder.
interface count_dir_decoder_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic [W-1:0] in_count;

    modport master (output in_valid, output in_count);
    modport slave  (input  in_valid, input  in_count);
endinterface

// File: rtl/count_step_classify.sv
// Combinational classification of one counter step against the reference sample.
module count_step_classify
    import count_dir_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] in_count,
    input  logic [W-1:0] ref_val,
    output step_t        step,
    output logic         wrap
);
    logic [W-1:0] delta;
    logic [W-1:0] one;

    always_comb begin
        one   = '0;
        one[0] = 1'b1;
        delta = in_count - ref_val;
        step  = STEP_BAD;
        wrap  = 1'b0;
        // Up is tested first so that for W=1 (+1 == all-ones) the step counts as up.
        if (delta == one) begin
            step = STEP_UP;
            wrap = (ref_val == '1);
        end else if (delta == '1) begin
            step = STEP_DOWN;
            wrap = (ref_val == '0);
        end
    end
endmodule

// File: rtl/count_dir_decoder.sv
// Tracks an observed up/down counter, reporting direction, wraps, reversals and illegal steps.
module count_dir_decoder
    import count_dir_pkg::*;
#(
    parameter int W  = 8,
    parameter int EW = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    count_dir_decoder_if.slave        smp,
    input  logic                      err_clr,
    output logic                      dir_valid,
    output logic                      dir_up,
    output logic                      step_err,
    output logic                      wrap_pulse,
    output logic                      dir_chg,
    output logic                      err_sticky,
    output logic [EW-1:0]             err_cnt
);
    state_t        state_q, state_d;
    logic [W-1:0]  ref_q, ref_d;
    logic          dir_valid_d, dir_up_d, step_err_d, wrap_d, dir_chg_d, sticky_d;
    logic [EW-1:0] cnt_base, cnt_d;
    step_t         step;
    logic          wrap;

    count_step_classify #(.W(W)) u_classify (
        .in_count (smp.in_count),
        .ref_val  (ref_q),
        .step     (step),
        .wrap     (wrap)
    );

    always_comb begin
        state_d     = state_q;
        ref_d       = ref_q;
        dir_valid_d = dir_valid;
        dir_up_d    = dir_up;
        step_err_d  = 1'b0;
        wrap_d      = 1'b0;
        dir_chg_d   = 1'b0;
        // A clear and an error in the same cycle count the error from zero.
        cnt_base    = err_clr ? '0 : err_cnt;
        sticky_d    = err_clr ? 1'b0 : err_sticky;
        cnt_d       = cnt_base;
        if (smp.in_valid) begin
            ref_d = smp.in_count;
            if (state_q == NO_REF) begin
                state_d = ARMED;
            end else begin
                unique case (step)
                    STEP_UP: begin
                        state_d     = UP;
                        dir_valid_d = 1'b1;
                        dir_up_d    = 1'b1;
                        wrap_d      = wrap;
                        dir_chg_d   = (state_q == DOWN);
                    end
                    STEP_DOWN: begin
                        state_d     = DOWN;
                        dir_valid_d = 1'b1;
                        dir_up_d    = 1'b0;
                        wrap_d      = wrap;
                        dir_chg_d   = (state_q == UP);
                    end
                    default: begin
                        state_d     = ARMED;
                        dir_valid_d = 1'b0;
                        step_err_d  = 1'b1;
                        sticky_d    = 1'b1;
                        cnt_d       = (cnt_base == '1) ? cnt_base : cnt_base + 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= NO_REF;
            ref_q      <= '0;
            dir_valid  <= 1'b0;
            dir_up     <= 1'b0;
            step_err   <= 1'b0;
            wrap_pulse <= 1'b0;
            dir_chg    <= 1'b0;
            err_sticky <= 1'b0;
            err_cnt    <= '0;
        end else begin
            state_q    <= state_d;
            ref_q      <= ref_d;
            dir_valid  <= dir_valid_d;
            dir_up     <= dir_up_d;
            step_err   <= step_err_d;
            wrap_pulse <= wrap_d;
            dir_chg    <= dir_chg_d;
            err_sticky <= sticky_d;
            err_cnt    <= cnt_d;
        end
    end
endmodule

// File: tb/tb_count_dir_decoder.sv
// Directed vector bench for count_dir_decoder (W=8 main instance, W=1/EW=2 corner instance).
module tb_count_dir_decoder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, err_clr;
    logic       dv, up, se, wr, ch, st;
    logic [7:0] ec;
    count_dir_decoder_if #(.W(8)) sif ();

    count_dir_decoder #(.W(8), .EW(8)) dut (
        .clk(clk), .reset(reset), .smp(sif.slave), .err_clr(err_clr),
        .dir_valid(dv), .dir_up(up), .step_err(se), .wrap_pulse(wr),
        .dir_chg(ch), .err_sticky(st), .err_cnt(ec)
    );

    logic       reset1, err_clr1;
    logic       dv1, up1, se1, wr1, ch1, st1;
    logic [1:0] ec1;
    count_dir_decoder_if #(.W(1)) sif1 ();

    count_dir_decoder #(.W(1), .EW(2)) dut1 (
        .clk(clk), .reset(reset1), .smp(sif1.slave), .err_clr(err_clr1),
        .dir_valid(dv1), .dir_up(up1), .step_err(se1), .wrap_pulse(wr1),
        .dir_chg(ch1), .err_sticky(st1), .err_cnt(ec1)
    );

    typedef struct {
        logic       rst;
        logic       v;
        logic [7:0] cnt;
        logic       clr;
        logic [5:0] flags;   // {dir_valid, dir_up, step_err, wrap, dir_chg, sticky}
        logic [7:0] ecnt;
    } vec_t;

    vec_t vq[$];
    int   tests = 0;
    int   fails = 0;

    function automatic vec_t mk(logic r, logic v, logic [7:0] c, logic clr,
                                logic [5:0] f, logic [7:0] e);
        vec_t t;
        t.rst = r; t.v = v; t.cnt = c; t.clr = clr; t.flags = f; t.ecnt = e;
        return t;
    endfunction

    task automatic check(input string name, input logic [13:0] got, input logic [13:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got flags=%b cnt=%h, expected flags=%b cnt=%h",
                     name, got[13:8], got[7:0], exp[13:8], exp[7:0]);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [7:0] c, input logic clr);
        reset = r; sif.in_valid = v; sif.in_count = c; err_clr = clr;
        @(posedge clk);
        #1;
        reset = 1'b0; sif.in_valid = 1'b0; err_clr = 1'b0;
    endtask

    task automatic drive1(input logic r, input logic v, input logic c);
        reset1 = r; sif1.in_valid = v; sif1.in_count = c; err_clr1 = 1'b0;
        @(posedge clk);
        #1;
        reset1 = 1'b0; sif1.in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; err_clr = 1'b0; sif.in_valid = 1'b0; sif.in_count = '0;
        reset1 = 1'b1; err_clr1 = 1'b0; sif1.in_valid = 1'b0; sif1.in_count = '0;

        // walking up 5,6,7 then idle hold
        vq.push_back(mk(1, 0, 8'h00, 0, 6'b000000, 8'h00));
        vq.push_back(mk(0, 1, 8'h05, 0, 6'b000000, 8'h00));
        vq.push_back(mk(0, 1, 8'h06, 0, 6'b110000, 8'h00));
        vq.push_back(mk(0, 1, 8'h07, 0, 6'b110000, 8'h00));
        vq.push_back(mk(0, 0, 8'h07, 0, 6'b110000, 8'h00));
        // up through the all-ones boundary
        vq.push_back(mk(1, 0, 8'h00, 0, 6'b000000, 8'h00));
        vq.push_back(mk(0, 1, 8'hFE, 0, 6'b000000, 8'h00));
        vq.push_back(mk(0, 1, 8'hFF, 0, 6'b110000, 8'h00));
        vq.push_back(mk(0, 1, 8'h00, 0, 6'b110100, 8'h00));
        vq.push_back(mk(0, 1, 8'h01, 0, 6'b110000, 8'h00));
        // reversals, zero step, big step, clear
        vq.push_back(mk(1, 0, 8'h00, 0, 6'b000000, 8'h00));
        vq.push_back(mk(0, 1, 8'h10, 0, 6'b000000, 8'h00));
        vq.push_back(mk(0, 1, 8'h11, 0, 6'b110000, 8'h00));
        vq.push_back(mk(0, 1, 8'h10, 0, 6'b100010, 8'h00));
        vq.push_back(mk(0, 1, 8'h11, 0, 6'b110010, 8'h00));
        vq.push_back(mk(0, 1, 8'h10, 0, 6'b100010, 8'h00));
        vq.push_back(mk(0, 1, 8'h10, 0, 6'b001001, 8'h01));
        vq.push_back(mk(0, 1, 8'h11, 0, 6'b110001, 8'h01));
        vq.push_back(mk(0, 1, 8'h13, 0, 6'b011001, 8'h02));
        vq.push_back(mk(0, 0, 8'h13, 1, 6'b010000, 8'h00));
        vq.push_back(mk(0, 1, 8'h14, 0, 6'b110000, 8'h00));
        // reset while tracking up with a valid sample
        vq.push_back(mk(1, 1, 8'h15, 0, 6'b000000, 8'h00));
        vq.push_back(mk(0, 1, 8'h20, 0, 6'b000000, 8'h00));
        vq.push_back(mk(0, 1, 8'h21, 0, 6'b110000, 8'h00));
        // down through zero
        vq.push_back(mk(1, 0, 8'h00, 0, 6'b000000, 8'h00));
        vq.push_back(mk(0, 1, 8'h00, 0, 6'b000000, 8'h00));
        vq.push_back(mk(0, 1, 8'hFF, 0, 6'b100100, 8'h00));
        vq.push_back(mk(0, 1, 8'hFE, 0, 6'b100000, 8'h00));
        vq.push_back(mk(0, 1, 8'hFF, 0, 6'b110010, 8'h00));
        vq.push_back(mk(0, 1, 8'h00, 0, 6'b110100, 8'h00));

        @(posedge clk);
        #1;
        foreach (vq[i]) begin
            drive(vq[i].rst, vq[i].v, vq[i].cnt, vq[i].clr);
            check($sformatf("vec%0d", i), {dv, up, se, wr, ch, st, ec}, {vq[i].flags, vq[i].ecnt});
        end

        // error counter saturation with alternating 00/80 samples
        drive(1, 0, 8'h00, 0);
        for (int i = 0; i <= 300; i++) begin
            drive(0, 1, (i % 2 == 1) ? 8'h80 : 8'h00, 0);
            if (i == 254)
                check("sat254", {dv, up, se, wr, ch, st, ec}, {6'b001001, 8'hFE});
            if (i == 300)
                check("sat300", {dv, up, se, wr, ch, st, ec}, {6'b001001, 8'hFF});
        end
        drive(0, 1, 8'h80, 1);
        check("clr_with_err", {dv, up, se, wr, ch, st, ec}, {6'b001001, 8'h01});
        drive(0, 0, 8'h80, 1);
        check("clr_only", {dv, up, se, wr, ch, st, ec}, {6'b000000, 8'h00});

        // W=1: every nonzero step is up; EW=2 saturates at 3
        drive1(1, 0, 1'b0);
        check("w1_reset", {dv1, up1, se1, wr1, ch1, st1, 6'b0, ec1}, 14'b0);
        drive1(0, 1, 1'b0);
        check("w1_arm", {dv1, up1, se1, wr1, ch1, st1, 6'b0, ec1}, 14'b0);
        drive1(0, 1, 1'b1);
        check("w1_up", {dv1, up1, se1, wr1, ch1, st1, 6'b0, ec1}, {6'b110000, 8'h00});
        drive1(0, 1, 1'b0);
        check("w1_upwrap", {dv1, up1, se1, wr1, ch1, st1, 6'b0, ec1}, {6'b110100, 8'h00});
        for (int i = 1; i <= 4; i++) begin
            drive1(0, 1, 1'b0);
            check($sformatf("w1_err%0d", i), {dv1, up1, se1, wr1, ch1, st1, 6'b0, ec1},
                  {6'b011001, 6'b0, (i > 3) ? 2'd3 : 2'(i)});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
